fast_frame_sequencer: RTL and testbench
=======================================

# fast_frame_sequencer

Controller that sequences one frame through the FAST_Detector datapath. On a frame request it walks the frame buffer in raster order, one read per cycle, and forwards each returned pixel to the detector with a single-cycle start pulse aligned to pixel 0. It then counts and caps detector keypoint flags, and closes the frame on the detector's end indication or on a drain timeout. It sits between the frame-buffer read port and FAST_Detector's i_pixel/i_start/o_flag/o_end.

## Interface
- WIDTH, 640, pixels per line
- HEIGHT, 480, lines per frame
- MEM_LAT, 1, frame-buffer read latency in cycles (1..4)
- MAX_KP, 1023, keypoint cap per frame
- DRAIN_MAX, 65535, cycles allowed between last address issue and i_det_end
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_frame_req  in  1  start-of-frame request, sampled in IDLE only
- o_busy  out  1  high from the cycle after an accepted request until DONE inclusive
- o_mem_ren  out  1  frame-buffer read enable
- o_mem_addr  out  19  read address, raster index y*WIDTH+x
- i_mem_rdata  in  8  read data, valid MEM_LAT cycles after o_mem_ren
- o_pixel  out  8  pixel to detector; 0 when no valid pixel
- o_start  out  1  one-cycle pulse aligned with pixel 0
- i_det_flag  in  1  detector keypoint valid
- i_det_end  in  1  detector end-of-frame
- o_kp_accept  out  1  combinational: i_det_flag && busy && kp_count < MAX_KP
- o_kp_count  out  16  accepted keypoints this frame
- o_frame_done  out  1  one-cycle pulse at frame close
- o_err_overrun  out  1  sticky: request seen while busy
- o_err_timeout  out  1  sticky: drain timeout

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: i_frame_req=1 -> FETCH; clears kp_count, address counter, drain counter, both error flags.
- FETCH: o_mem_ren=1 every cycle; o_mem_addr increments 0..WIDTH*HEIGHT-1 with no gaps. After issuing the last address -> DRAIN.
- DRAIN: drain counter increments each cycle. i_det_end=1 -> DONE. Counter reaching DRAIN_MAX -> DONE with o_err_timeout set.
- DONE: o_frame_done=1 for one cycle -> IDLE.
- Pixel path: ren and first-address markers are delayed through an (MAX 4)-deep shift register tapped at MAX_LAT index MEM_LAT. o_pixel is registered from i_mem_rdata when the delayed valid is set, else 0. o_start is the registered delayed first marker.
- Keypoints: kp_count increments on o_kp_accept in FETCH, DRAIN or DONE and saturates at MAX_KP. Flags at saturation are dropped (o_kp_accept=0).
- Simultaneous events: i_det_flag with i_det_end counts the flag. i_det_end in FETCH is ignored. i_frame_req outside IDLE is ignored and sets o_err_overrun.
- Reset mid-frame: all state and outputs return to reset values immediately; no o_frame_done is emitted and in-flight read data is discarded.

## Timing
- Reset values: o_busy=0, o_mem_ren=0, o_mem_addr=0, o_pixel=0, o_start=0, o_kp_count=0, o_frame_done=0, both error flags 0; state IDLE.
- Request sampled at cycle T -> o_mem_ren=1 with addr 0 at T+1.
- Address n is issued at T+1+n. Its pixel appears on o_pixel at T+2+n+MEM_LAT.
- o_start is high exactly at T+2+MEM_LAT.
- The last address is issued at T+WIDTH*HEIGHT. DRAIN is entered the next cycle.
- o_frame_done is high the cycle after the DRAIN exit condition. A new request is accepted the cycle after that (IDLE).
- Address width is fixed at 19 bits (covers 640x480). The address counter never wraps within a frame.

## Structure
- Shared package fast_pkg holds: state enum, ADDR_W=19, KP_W=16, MAX_LAT=4 constant.
- One sub-module, fast_seq_delay: parameterised-depth shift register carrying {valid, first}, with async active-high clear.
- The FSM, address/drain/keypoint counters and output registers live in the top.

## Test plan
All scenarios use WIDTH=8, HEIGHT=4, MEM_LAT=2 unless stated.

- Basic frame, memory model returns addr[7:0]: req at T -> ren at T+1..T+32 with addr 0..31; o_pixel 0..31 on T+4..T+35; o_start only at T+4.
- 5 flags during DRAIN, then i_det_end at T+40 -> o_kp_count=5, o_frame_done at T+41, o_busy low at T+42.
- MAX_KP=3, 6 flags including one coincident with i_det_end -> o_kp_accept high for the first 3 only; o_kp_count=3.
- DRAIN_MAX=10, no i_det_end -> DONE entered 10 cycles into DRAIN; o_err_timeout=1; o_frame_done pulses once.
- i_frame_req during FETCH -> o_err_overrun=1; address sequence unaffected. The next accepted req clears the flag.
- i_rst asserted at addr 12 -> all outputs 0 the same cycle. After release, a new req restarts at addr 0 and o_start fires once.

Source files
------------

// File: rtl/fast_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fast_pkg
// Purpose  : Shared types and constants for the FAST frame sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fast_pkg;

    localparam int ADDR_W  = 19;
    localparam int KP_W    = 16;
    localparam int MAX_LAT = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Marker carried alongside each read through the latency pipeline.
    typedef struct packed {
        logic valid;
        logic first;
    } mark_t;

    function automatic int clamp_lat(input int lat);
        if (lat < 1)
            return 1;
        else if (lat > MAX_LAT)
            return MAX_LAT;
        else
            return lat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fast_seq_delay.sv
`default_nettype none
// ============================================================================
// Module   : fast_seq_delay
// Purpose  : DEPTH-stage shift register for the {valid, first} read markers.
// Revision : 1.0 - initial release
// ============================================================================
module fast_seq_delay #(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] shift_in,
    output logic [1:0] shift_out
);

    logic [2*DEPTH-1:0] sr;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    sr <= '0;
                else
                    sr <= shift_in;
            end
        end else begin : g_chain
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    sr <= '0;
                else
                    sr <= {sr[2*DEPTH-3:0], shift_in};
            end
        end
    endgenerate

    assign shift_out = sr[2*DEPTH-1 -: 2];

endmodule
`default_nettype wire

// File: rtl/fast_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fast_frame_sequencer
// Purpose  : Walks one frame buffer in raster order into the FAST detector,
//            counts keypoints and closes the frame on end or drain timeout.
// Revision : 1.0 - initial release
// ============================================================================
module fast_frame_sequencer
    import fast_pkg::*;
#(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int MEM_LAT   = 1,
    parameter int MAX_KP    = 1023,
    parameter int DRAIN_MAX = 65535
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_frame_req,
    output logic              o_busy,
    output logic              o_mem_ren,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [7:0]        i_mem_rdata,
    output logic [7:0]        o_pixel,
    output logic              o_start,
    input  logic              i_det_flag,
    input  logic              i_det_end,
    output logic              o_kp_accept,
    output logic [KP_W-1:0]   o_kp_count,
    output logic              o_frame_done,
    output logic              o_err_overrun,
    output logic              o_err_timeout
);

    localparam int                LAT       = clamp_lat(MEM_LAT);
    localparam int                DRAIN_W   = $clog2(DRAIN_MAX + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_MAX - 1);
    localparam logic [KP_W-1:0]   KP_CAP    = KP_W'(MAX_KP);

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   addr;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic [KP_W-1:0]     kp_count;
    logic                err_overrun;
    logic                err_timeout;
    logic [7:0]          pixel;
    logic                start;

    logic                busy;
    logic                mem_ren;
    logic                frame_done;
    logic                req_accept;
    logic                last_addr;
    logic                drain_expired;
    logic                kp_accept;
    mark_t               mark_in;
    mark_t               mark_tap;

    assign req_accept    = (state == S_IDLE) && i_frame_req;
    assign last_addr     = (addr == LAST_ADDR);
    // A coincident end indication wins over the timeout.
    assign drain_expired = (state == S_DRAIN) && !i_det_end && (drain_cnt == DRAIN_LAST);
    assign kp_accept     = i_det_flag && busy && (kp_count < KP_CAP);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b1;
        mem_ren    = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (i_frame_req)
                    next_state = S_FETCH;
            end
            S_FETCH: begin
                mem_ren = 1'b1;
                if (last_addr)
                    next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (i_det_end || drain_expired)
                    next_state = S_DONE;
            end
            S_DONE: begin
                frame_done = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr        <= '0;
            drain_cnt   <= '0;
            kp_count    <= '0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else if (req_accept) begin
            addr        <= '0;
            drain_cnt   <= '0;
            kp_count    <= '0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            // Counter parks on the last address so it never wraps within a frame.
            if (state == S_FETCH && !last_addr)
                addr <= addr + 1'b1;
            if (state == S_DRAIN)
                drain_cnt <= drain_cnt + 1'b1;
            if (kp_accept)
                kp_count <= kp_count + 1'b1;
            if (i_frame_req && state != S_IDLE)
                err_overrun <= 1'b1;
            if (drain_expired)
                err_timeout <= 1'b1;
        end
    end

    assign mark_in.valid = mem_ren;
    assign mark_in.first = mem_ren && (addr == '0);

    // Only LAT stages are built; deeper taps of the MAX_LAT line are never used.
    fast_seq_delay #(
        .DEPTH (LAT)
    ) u_delay (
        .clk       (i_clk),
        .rst       (i_rst),
        .shift_in  (mark_in),
        .shift_out (mark_tap)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pixel <= '0;
            start <= 1'b0;
        end else begin
            pixel <= mark_tap.valid ? i_mem_rdata : 8'd0;
            start <= mark_tap.first;
        end
    end

    assign o_busy        = busy;
    assign o_mem_ren     = mem_ren;
    assign o_mem_addr    = addr;
    assign o_pixel       = pixel;
    assign o_start       = start;
    assign o_kp_accept   = kp_accept;
    assign o_kp_count    = kp_count;
    assign o_frame_done  = frame_done;
    assign o_err_overrun = err_overrun;
    assign o_err_timeout = err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_fast_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fast_frame_sequencer
// Purpose  : Directed self-checking bench for fast_frame_sequencer (8x4 frame).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fast_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_req;
    logic        det_flag;
    logic        det_end;

    logic        busy_a, ren_a, start_a, acc_a, done_a, ovr_a, tmo_a;
    logic [18:0] addr_a;
    logic [7:0]  pixel_a, rdata_a, m1_a;
    logic [15:0] kpc_a;

    logic        busy_c, ren_c, start_c, acc_c, done_c, ovr_c, tmo_c;
    logic [18:0] addr_c;
    logic [7:0]  pixel_c, rdata_c, m1_c;
    logic [15:0] kpc_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Two-cycle read latency frame buffer; data is the low address byte.
    always @(posedge clk) begin
        m1_a    <= ren_a ? addr_a[7:0] : 8'hEE;
        rdata_a <= m1_a;
        m1_c    <= ren_c ? addr_c[7:0] : 8'hEE;
        rdata_c <= m1_c;
    end

    fast_frame_sequencer #(
        .WIDTH(8), .HEIGHT(4), .MEM_LAT(2), .MAX_KP(1023), .DRAIN_MAX(10)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_frame_req(frame_req), .o_busy(busy_a),
        .o_mem_ren(ren_a), .o_mem_addr(addr_a), .i_mem_rdata(rdata_a),
        .o_pixel(pixel_a), .o_start(start_a), .i_det_flag(det_flag),
        .i_det_end(det_end), .o_kp_accept(acc_a), .o_kp_count(kpc_a),
        .o_frame_done(done_a), .o_err_overrun(ovr_a), .o_err_timeout(tmo_a)
    );

    fast_frame_sequencer #(
        .WIDTH(8), .HEIGHT(4), .MEM_LAT(2), .MAX_KP(3), .DRAIN_MAX(10)
    ) dut_cap (
        .i_clk(clk), .i_rst(rst), .i_frame_req(frame_req), .o_busy(busy_c),
        .o_mem_ren(ren_c), .o_mem_addr(addr_c), .i_mem_rdata(rdata_c),
        .o_pixel(pixel_c), .o_start(start_c), .i_det_flag(det_flag),
        .i_det_end(det_end), .o_kp_accept(acc_c), .o_kp_count(kpc_c),
        .o_frame_done(done_c), .o_err_overrun(ovr_c), .o_err_timeout(tmo_c)
    );

    task automatic test_reset();
        rst = 1'b1; frame_req = 1'b0; det_flag = 1'b1; det_end = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        checks++; if (ren_a !== 1'b0) begin errors++; $display("FAIL reset_ren: got %b expected 0", ren_a); end
        checks++; if (addr_a !== 19'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", addr_a); end
        checks++; if (pixel_a !== 8'd0) begin errors++; $display("FAIL reset_pixel: got %0d expected 0", pixel_a); end
        checks++; if (start_a !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", start_a); end
        checks++; if (kpc_a !== 16'd0) begin errors++; $display("FAIL reset_kpc: got %0d expected 0", kpc_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_a); end
        checks++; if ({ovr_a, tmo_a} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", {ovr_a, tmo_a}); end
        checks++; if (acc_a !== 1'b0) begin errors++; $display("FAIL reset_accept: got %b expected 0", acc_a); end
        rst = 1'b0; det_flag = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (busy_a !== 1'b0 || ren_a !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy %b ren %b expected 0 0", busy_a, ren_a); end
    endtask

    // Basic frame plus 5 flags during DRAIN and i_det_end at T+40.
    task automatic test_basic_frame();
        int exp_kp;
        @(posedge clk); #1;
        frame_req = 1'b1;
        for (int k = 1; k <= 42; k++) begin
            @(posedge clk); #1;
            frame_req = 1'b0;
            det_flag  = (k >= 34 && k <= 38);
            det_end   = (k == 40);
            #1;
            exp_kp = (k <= 34) ? 0 : ((k >= 39) ? 5 : k - 34);
            checks++; if (ren_a !== (k <= 32)) begin errors++; $display("FAIL basic_ren k=%0d: got %b expected %b", k, ren_a, (k <= 32)); end
            if (k <= 32) begin
                checks++; if (addr_a !== 19'(k - 1)) begin errors++; $display("FAIL basic_addr k=%0d: got %0d expected %0d", k, addr_a, k - 1); end
            end
            checks++; if (pixel_a !== ((k >= 4 && k <= 35) ? 8'(k - 4) : 8'd0)) begin errors++; $display("FAIL basic_pixel k=%0d: got %0d", k, pixel_a); end
            checks++; if (start_a !== (k == 4)) begin errors++; $display("FAIL basic_start k=%0d: got %b expected %b", k, start_a, (k == 4)); end
            checks++; if (kpc_a !== 16'(exp_kp)) begin errors++; $display("FAIL basic_kpc k=%0d: got %0d expected %0d", k, kpc_a, exp_kp); end
            checks++; if (acc_a !== det_flag) begin errors++; $display("FAIL basic_accept k=%0d: got %b expected %b", k, acc_a, det_flag); end
            checks++; if (done_a !== (k == 41)) begin errors++; $display("FAIL basic_done k=%0d: got %b expected %b", k, done_a, (k == 41)); end
            checks++; if (busy_a !== (k <= 41)) begin errors++; $display("FAIL basic_busy k=%0d: got %b expected %b", k, busy_a, (k <= 41)); end
        end
        det_flag = 1'b0; det_end = 1'b0;
    endtask

    // Cap of 3 on dut_cap; 6 flags, one coincident with end; end in FETCH ignored.
    task automatic test_kp_cap();
        int  exp_a;
        int  exp_c;
        logic exp_acc_c;
        exp_a = 0; exp_c = 0;
        @(posedge clk); #1;
        frame_req = 1'b1;
        for (int k = 1; k <= 42; k++) begin
            @(posedge clk); #1;
            frame_req = 1'b0;
            det_flag  = (k inside {34, 35, 36, 37, 38, 40});
            det_end   = (k == 10 || k == 40);
            #1;
            exp_acc_c = det_flag && (exp_c < 3);
            checks++; if (ren_a !== (k <= 32)) begin errors++; $display("FAIL cap_ren k=%0d: got %b expected %b", k, ren_a, (k <= 32)); end
            checks++; if (done_a !== (k == 41)) begin errors++; $display("FAIL cap_done k=%0d: got %b expected %b", k, done_a, (k == 41)); end
            checks++; if (kpc_a !== 16'(exp_a)) begin errors++; $display("FAIL cap_kpc_a k=%0d: got %0d expected %0d", k, kpc_a, exp_a); end
            checks++; if (kpc_c !== 16'(exp_c)) begin errors++; $display("FAIL cap_kpc_c k=%0d: got %0d expected %0d", k, kpc_c, exp_c); end
            checks++; if (acc_c !== exp_acc_c) begin errors++; $display("FAIL cap_accept k=%0d: got %b expected %b", k, acc_c, exp_acc_c); end
            if (det_flag) exp_a++;
            if (exp_acc_c) exp_c++;
        end
        checks++; if (kpc_a !== 16'd6) begin errors++; $display("FAIL cap_final_a: got %0d expected 6", kpc_a); end
        checks++; if (kpc_c !== 16'd3) begin errors++; $display("FAIL cap_final_c: got %0d expected 3", kpc_c); end
        det_flag = 1'b0; det_end = 1'b0;
    endtask

    // DRAIN_MAX=10 with no end: DONE at T+43.
    task automatic test_timeout();
        @(posedge clk); #1;
        frame_req = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk); #1;
            frame_req = 1'b0;
            #1;
            checks++; if (done_a !== (k == 43)) begin errors++; $display("FAIL tmo_done k=%0d: got %b expected %b", k, done_a, (k == 43)); end
            checks++; if (tmo_a !== (k >= 43)) begin errors++; $display("FAIL tmo_flag k=%0d: got %b expected %b", k, tmo_a, (k >= 43)); end
            checks++; if (busy_a !== (k <= 43)) begin errors++; $display("FAIL tmo_busy k=%0d: got %b expected %b", k, busy_a, (k <= 43)); end
        end
    endtask

    // Request during FETCH flags overrun; the next accepted request clears it.
    task automatic test_overrun();
        @(posedge clk); #1;
        frame_req = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            @(posedge clk); #1;
            frame_req = (k == 5 || k == 36);
            det_end   = (k == 34);
            #1;
            if (k <= 32) begin
                checks++; if (addr_a !== 19'(k - 1)) begin errors++; $display("FAIL ovr_addr k=%0d: got %0d expected %0d", k, addr_a, k - 1); end
            end
            checks++; if (ovr_a !== (k >= 6)) begin errors++; $display("FAIL ovr_flag k=%0d: got %b expected %b", k, ovr_a, (k >= 6)); end
            checks++; if (tmo_a !== 1'b0) begin errors++; $display("FAIL ovr_tmo_clear k=%0d: got %b expected 0", k, tmo_a); end
            checks++; if (done_a !== (k == 35)) begin errors++; $display("FAIL ovr_done k=%0d: got %b expected %b", k, done_a, (k == 35)); end
        end
        @(posedge clk); #1;
        frame_req = 1'b0; det_end = 1'b0;
        #1;
        checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL ovr_cleared: got %b expected 0", ovr_a); end
        checks++; if (busy_a !== 1'b1 || addr_a !== 19'd0) begin errors++; $display("FAIL ovr_restart: busy %b addr %0d expected 1 0", busy_a, addr_a); end
    endtask

    // Continues the frame started by test_overrun; reset lands on address 12.
    task automatic test_reset_mid_frame();
        for (int j = 1; j <= 12; j++) begin
            @(posedge clk); #1;
        end
        checks++; if (addr_a !== 19'd12) begin errors++; $display("FAIL mid_addr_before: got %0d expected 12", addr_a); end
        rst = 1'b1;
        #1;
        checks++; if ({busy_a, ren_a, start_a, done_a, ovr_a, tmo_a} !== 6'b0) begin errors++; $display("FAIL mid_flags: got %b expected 000000", {busy_a, ren_a, start_a, done_a, ovr_a, tmo_a}); end
        checks++; if (addr_a !== 19'd0 || pixel_a !== 8'd0 || kpc_a !== 16'd0) begin errors++; $display("FAIL mid_values: addr %0d pixel %0d kpc %0d expected 0 0 0", addr_a, pixel_a, kpc_a); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            checks++; if (pixel_a !== 8'd0 || start_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL mid_flush j=%0d: pixel %0d start %b done %b expected 0 0 0", j, pixel_a, start_a, done_a); end
        end
        frame_req = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            frame_req = 1'b0;
            #1;
            checks++; if (addr_a !== 19'(k - 1) || ren_a !== 1'b1) begin errors++; $display("FAIL mid_re_addr k=%0d: addr %0d ren %b expected %0d 1", k, addr_a, ren_a, k - 1); end
            checks++; if (start_a !== (k == 4)) begin errors++; $display("FAIL mid_re_start k=%0d: got %b expected %b", k, start_a, (k == 4)); end
            checks++; if (pixel_a !== ((k >= 4) ? 8'(k - 4) : 8'd0)) begin errors++; $display("FAIL mid_re_pixel k=%0d: got %0d", k, pixel_a); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; frame_req = 1'b0; det_flag = 1'b0; det_end = 1'b0;
        test_reset();
        test_basic_frame();
        test_kp_cap();
        test_timeout();
        test_overrun();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
